// File: rtl/packet_loader_if.sv
// Handshake bundle for packet_loader: request intake, instruction fetch, packet output.
// The slave view belongs to packet_loader; the master view to whatever drives it.
interface packet_loader_if #(
    parameter int REQ_W  = 98,
    parameter int PKT_W  = 114,
    parameter int INST_W = 32
);
    logic              recv_pr_valid;
    logic [REQ_W-1:0]  recv_pr_data;
    logic              recv_pr_ready;

    logic              mem_req_valid;
    logic [15:0]       mem_req_addr;
    logic              mem_req_ready;
    logic              mem_rsp_valid;
    logic [INST_W-1:0] mem_rsp_data;

    logic              send_p_valid;
    logic [PKT_W-1:0]  send_p_data;
    logic              send_p_ready;

    modport slave (
        input  recv_pr_valid, recv_pr_data, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               send_p_ready,
        output recv_pr_ready, mem_req_valid, mem_req_addr, send_p_valid, send_p_data
    );

    modport master (
        output recv_pr_valid, recv_pr_data, mem_req_ready, mem_rsp_valid, mem_rsp_data,
               send_p_ready,
        input  recv_pr_ready, mem_req_valid, mem_req_addr, send_p_valid, send_p_data
    );
endinterface

// File: rtl/packet_loader.sv
// Accepts one packet request at a time, fetches the instruction word for execution
// requests, and emits the assembled packet downstream. Outputs decode only state/registers.
module packet_loader (
    input  logic          clk,
    input  logic          rst,
    packet_loader_if.slave bus,
    output logic          busy,
    output logic [31:0]   sent_count
);
    localparam logic [1:0] DEST_OPTION_EXEC = 2'b00;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_SEND} state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  opt_q;
    logic [15:0] addr_q;
    logic [15:0] tag_q;
    logic [31:0] inst_q;
    logic [31:0] data1_q;
    logic [31:0] data2_q;
    logic [31:0] sent_count_q;

    logic req_fire;
    logic mem_fire;
    logic rsp_take;
    logic send_fire;

    assign req_fire  = (state_q == S_IDLE) && bus.recv_pr_valid;
    assign mem_fire  = (state_q == S_REQ)  && bus.mem_req_ready;
    // Responses outside S_WAIT (including one coincident with the read accept) are dropped.
    assign rsp_take  = (state_q == S_WAIT) && bus.mem_rsp_valid;
    assign send_fire = (state_q == S_SEND) && bus.send_p_ready;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (req_fire)
                        state_d = (bus.recv_pr_data[97:96] == DEST_OPTION_EXEC) ? S_REQ : S_SEND;
            S_REQ:  if (mem_fire)  state_d = S_WAIT;
            S_WAIT: if (rsp_take)  state_d = S_SEND;
            S_SEND: if (send_fire) state_d = S_IDLE;
            default:               state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            opt_q        <= '0;
            addr_q       <= '0;
            tag_q        <= '0;
            inst_q       <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
            sent_count_q <= '0;
        end else begin
            state_q <= state_d;
            if (req_fire) begin
                opt_q   <= bus.recv_pr_data[97:96];
                addr_q  <= bus.recv_pr_data[95:80];
                tag_q   <= bus.recv_pr_data[79:64];
                data1_q <= bus.recv_pr_data[63:32];
                data2_q <= bus.recv_pr_data[31:0];
                if (bus.recv_pr_data[97:96] != DEST_OPTION_EXEC) inst_q <= '0;
            end
            if (rsp_take)  inst_q       <= bus.mem_rsp_data;
            if (send_fire) sent_count_q <= sent_count_q + 32'd1;
        end
    end

    assign bus.recv_pr_ready = (state_q == S_IDLE);
    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.mem_req_addr  = addr_q;
    assign bus.send_p_valid  = (state_q == S_SEND);
    assign bus.send_p_data   = {opt_q, tag_q, inst_q, data1_q, data2_q};
    assign busy              = (state_q != S_IDLE);
    assign sent_count        = sent_count_q;
endmodule

// File: doc/packet_loader.md
# packet_loader

Receiving end of the packet-request channel. Accepts one packet request at a time from the startup block or any other requester, fetches the addressed instruction word from instruction memory when the request targets execution, and emits a fully formed packet downstream over a valid/ready channel. It sits between the packet-request producers and the execution pipeline and keeps at most one request in flight.

## Interface
- PACKET_REQUEST_WIDTH, 98: request layout, MSB first.
  - opt[97:96]
  - addr[95:80]
  - tag[79:64]
  - data1[63:32]
  - data2[31:0]
- PACKET_WIDTH, 114: packet layout, MSB first.
  - opt[113:112]
  - tag[111:96]
  - inst[95:64]
  - data1[63:32]
  - data2[31:0]
- INST_WIDTH, 32: instruction memory word width.
- DEST_OPTION_EXEC, 2'b00: option code that requires an instruction fetch.
- CLK in 1: sole clock; all logic on rising edge.
- RST in 1: synchronous, active-high reset.
- RECV_PR_VALID in 1: request valid.
- RECV_PR_DATA in PACKET_REQUEST_WIDTH: request payload.
- RECV_PR_READY out 1: request accepted when VALID && READY.
- MEM_REQ_VALID out 1: instruction read request.
- MEM_REQ_ADDR out 16: word address, equal to the latched addr.
- MEM_REQ_READY in 1: memory accepts the read.
- MEM_RSP_VALID in 1: one-cycle response strobe; no back-pressure.
- MEM_RSP_DATA in INST_WIDTH: instruction word.
- SEND_P_VALID out 1: packet valid.
- SEND_P_DATA out PACKET_WIDTH: packet payload.
- SEND_P_READY in 1: downstream accepts.
- BUSY out 1: high in every state except S_IDLE.
- SENT_COUNT out 32: number of packets handed off, wraps modulo 2^32.

## Operation
- States:
  - S_IDLE (reset state)
  - S_REQ
  - S_WAIT
  - S_SEND
- S_IDLE: RECV_PR_READY=1. On handshake, latch opt/addr/tag/data1/data2.
  - If opt == DEST_OPTION_EXEC, go to S_REQ.
  - Otherwise clear the inst register to 0 and go to S_SEND.
- S_REQ: MEM_REQ_VALID=1 with MEM_REQ_ADDR=latched addr, held stable until MEM_REQ_READY. Handshake moves to S_WAIT.
- S_WAIT: on MEM_RSP_VALID, capture MEM_RSP_DATA into inst and go to S_SEND.
  - A response arriving in any other state is ignored.
- S_SEND: SEND_P_VALID=1 with SEND_P_DATA = {opt, tag, inst, data1, data2}, held stable until SEND_P_READY.
  - On handshake, increment SENT_COUNT (0xFFFFFFFF wraps to 0) and return to S_IDLE.
- RECV_PR_READY=0 outside S_IDLE. Requests presented while the block is busy are back-pressured, never dropped.
- All outputs are registered or decoded only from state and registers. No combinational path from any *_READY or *_VALID input to an output.

## Timing
- Reset values:
  - state = S_IDLE
  - RECV_PR_READY = 1 (first cycle after reset)
  - MEM_REQ_VALID = 0, MEM_REQ_ADDR = 0
  - SEND_P_VALID = 0, SEND_P_DATA = 0
  - BUSY = 0, SENT_COUNT = 0
- EXEC path, best case (memory ready, response one cycle after accept):
  - Request handshake at cycle c.
  - MEM_REQ_VALID at c+1.
  - MEM_RSP_VALID earliest at c+2.
  - SEND_P_VALID at c+3.
  - If SEND_P_READY at c+3, RECV_PR_READY returns at c+4.
- Non-EXEC path: handshake at c, SEND_P_VALID at c+1, RECV_PR_READY at c+2 if accepted.
- Throughput: one request per 2 cycles (non-EXEC) or 4 cycles (EXEC), best case.
- Reset asserted mid-operation:
  - Returns to S_IDLE the next cycle and drops the in-flight request and any captured instruction.
  - A late MEM_RSP_VALID after reset is ignored.
  - SENT_COUNT clears.
- MEM_RSP_VALID in the same cycle as the MEM_REQ handshake is not legal (memory latency is at least 1). It is ignored; S_WAIT is still entered.
- SEND_P_READY held low indefinitely: payload stays stable, BUSY stays high, no further requests are accepted.

## Test plan
- Reset, then one EXEC request (addr=0x0010, tag=0x0001, data1=0xAAAA5555, data2=0x12345678), memory returning 0xDEADBEEF one cycle later, SEND_P_READY=1.
  - MEM_REQ_ADDR=0x0010.
  - Packet {00, 0001, DEADBEEF, AAAA5555, 12345678} at accept+3.
  - SENT_COUNT=1.
- Non-EXEC request (opt=2'b01, tag=0x00FF).
  - No MEM_REQ_VALID.
  - Packet appears at accept+1 with inst=0.
- Back-pressure case:
  - MEM_REQ_READY low for 5 cycles, then SEND_P_READY low for 7 cycles.
  - MEM_REQ_ADDR and SEND_P_DATA stay stable throughout; RECV_PR_READY stays 0.
  - Exactly one packet is delivered.
- Reset during S_WAIT, then MEM_RSP_VALID arrives.
  - No packet is emitted; state S_IDLE; SENT_COUNT=0.
  - A subsequent request completes normally.
- Counter wrap:
  - Force SENT_COUNT to 0xFFFFFFFF, then send one packet; SENT_COUNT reads 0.
- Back-to-back traffic:
  - 100 randomized requests with random ready and response delays.
  - Output packets match a scoreboard in order with no loss or duplication.
  - MEM_RSP_VALID injected in S_IDLE or S_SEND is ignored.
